lb_reset_seq: RTL and testbench

- Parametrised reset sequencer; successor to the single-output board reset block.
- Takes the async board reset, a debounced push-button and a software reset request (PicoBlaze port write). Drives NUM_RESETS active-high domain resets.
- Domain resets release in index order, staggered, after a stretch period.
- Sits at the SoC top; feeds the processor, bus fabric and peripherals. Exposes a sticky reset-cause code for firmware.

---
 rtl/lb_reset_seq.sv | 167 ++++++++++++++++
 tb/tb_lb_reset_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lb_reset_seq.sv
// lb_reset_seq: parametrised SoC reset sequencer.
// Holds all domain resets through a stretch period after board reset or a
// soft trigger (debounced button or software request), then releases them
// one by one in index order with a fixed stagger. A sticky cause code records
// the most recent reset source.
module lb_reset_seq #(
    parameter int NUM_RESETS     = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  ext_btn,
    input  logic                  sw_reset_req,
    output logic [NUM_RESETS-1:0] system_reset,
    output logic                  reset_done,
    output logic [1:0]            reset_cause
);

    localparam int MAX_CNT = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = $clog2(NUM_RESETS + 1);
    localparam int FILT_W  = $clog2(FILTER_CYCLES + 1);

    localparam logic [1:0] CAUSE_BOARD  = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SW     = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [FILT_W-1:0]      filt_q;
    logic                   rst_released;
    logic                   btn_qual;
    logic                   trigger;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_RESETS-1:0]  sr_q, sr_d;
    logic                   done_q, done_d;
    logic [1:0]             cause_q, cause_d;

    // Board reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
    // NOTE: resetb clears the chain asynchronously so assertion never waits for a clock;
    // only the release is synchronised by shifting ones through the chain.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_released = rst_sync_q[SYNC_STAGES-1];

    // Push-button synchroniser into the clock domain.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) btn_sync_q <= '0;
        else         btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], ext_btn};
    end

    // Saturating run-length counter of synchronised button highs; any low clears it.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)                                   filt_q <= '0;
        else if (!btn_sync_q[SYNC_STAGES-1])           filt_q <= '0;
        else if (filt_q != FILT_W'(FILTER_CYCLES))     filt_q <= filt_q + FILT_W'(1);
    end

    assign btn_qual = (filt_q == FILT_W'(FILTER_CYCLES));
    assign trigger  = sw_reset_req | btn_qual;

    // Sequencer state and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '1;
            done_q  <= 1'b0;
            cause_q <= CAUSE_BOARD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic: soft trigger overrides everything, otherwise stretch then stagger.
    // NOTE: every signal gets its hold value first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        done_d  = done_q;
        cause_d = cause_q;

        if (trigger) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            sr_d    = '1;
            done_d  = 1'b0;
            cause_d = btn_qual ? CAUSE_BUTTON : CAUSE_SW;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (rst_released) begin
                        if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                            cnt_d   = '0;
                            sr_d[0] = 1'b0;
                            if (NUM_RESETS == 1) begin
                                state_d = ST_RUN;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_RELEASE;
                                idx_d   = IDX_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                        cnt_d = '0;
                        sr_d  = sr_q & ~(NUM_RESETS'(1) << idx_q);
                        if (idx_q == IDX_W'(NUM_RESETS - 1)) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Quiescent until the next soft trigger.
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sr_d    = '1;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign system_reset = sr_q;
    assign reset_done   = done_q;
    assign reset_cause  = cause_q;

endmodule

// File: tb/tb_lb_reset_seq.sv
// tb_lb_reset_seq: checks the default configuration and a small sweep
// configuration (NUM_RESETS=1, STRETCH_CYCLES=1, SYNC_STAGES=3) side by side
// against a timeline reference model: each output bit k is released once the
// edges elapsed since the last sequence anchor reach STRETCH + k*STAGGER.
module tb_lb_reset_seq;

    localparam int HIST_LEN = 8192;

    logic       clk = 1'b0;
    logic       resetb;
    logic       ext_btn;
    logic       sw_reset_req;
    logic [2:0] sr0;
    logic       done0;
    logic [1:0] cause0;
    logic [0:0] sr1;
    logic       done1;
    logic [1:0] cause1;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state, one slot per instance.
    int       n_edge [2];
    int       elapsed[2];
    logic [1:0] m_cause[2];
    bit       hist   [2][HIST_LEN];

    lb_reset_seq u_dut0 (
        .clk          (clk),
        .resetb       (resetb),
        .ext_btn      (ext_btn),
        .sw_reset_req (sw_reset_req),
        .system_reset (sr0),
        .reset_done   (done0),
        .reset_cause  (cause0)
    );

    lb_reset_seq #(
        .NUM_RESETS     (1),
        .SYNC_STAGES    (3),
        .STRETCH_CYCLES (1),
        .STAGGER_CYCLES (8),
        .FILTER_CYCLES  (4)
    ) u_dut1 (
        .clk          (clk),
        .resetb       (resetb),
        .ext_btn      (ext_btn),
        .sw_reset_req (sw_reset_req),
        .system_reset (sr1),
        .reset_done   (done1),
        .reset_cause  (cause1)
    );

    always #10 clk = ~clk;

    function automatic int p_num(int i);     return (i == 0) ? 3  : 1; endfunction
    function automatic int p_sync(int i);    return (i == 0) ? 2  : 3; endfunction
    function automatic int p_stretch(int i); return (i == 0) ? 16 : 1; endfunction
    function automatic int p_stagger(int i); return 8;                 endfunction
    function automatic int p_filter(int i);  return 4;                 endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n_edge[i]  = 0;
            elapsed[i] = -1;
            m_cause[i] = 2'b00;
        end
    endtask

    // A press fires at edge n when the FILTER raw samples taken at edges
    // n-SYNC-FILTER .. n-SYNC-1 were all high (synchroniser plus filter latency).
    function automatic bit btn_fire(int i);
        int lo = n_edge[i] - p_sync(i) - p_filter(i);
        int hi = n_edge[i] - p_sync(i) - 1;
        if (lo < 1) return 1'b0;
        for (int k = lo; k <= hi; k++)
            if (!hist[i][k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(int i);
        bit bf;
        bit trig;
        n_edge[i]++;
        bf   = btn_fire(i);
        trig = bf | sw_reset_req;
        if (n_edge[i] < HIST_LEN) hist[i][n_edge[i]] = ext_btn;
        if (trig) m_cause[i] = bf ? 2'b01 : 2'b10;
        if (n_edge[i] < p_sync(i))                       elapsed[i] = -1;
        else if (n_edge[i] == p_sync(i) || trig)          elapsed[i] = 0;
        else if (elapsed[i] < 100000)                     elapsed[i]++;
    endtask

    function automatic logic [31:0] exp_sr(int i);
        logic [31:0] v = '0;
        for (int k = 0; k < p_num(i); k++)
            v[k] = !(elapsed[i] >= 0 && elapsed[i] >= p_stretch(i) + k * p_stagger(i));
        return v;
    endfunction

    function automatic logic [31:0] exp_done(int i);
        return (exp_sr(i) == 32'd0) ? 32'd1 : 32'd0;
    endfunction

    task automatic compare_all();
        check("sr0",    32'(sr0),    exp_sr(0));
        check("done0",  32'(done0),  exp_done(0));
        check("cause0", 32'(cause0), 32'(m_cause[0]));
        check("sr1",    32'(sr1),    exp_sr(1));
        check("done1",  32'(done1),  exp_done(1));
        check("cause1", 32'(cause1), 32'(m_cause[1]));
    endtask

    // Advance one clock: update the model at the rising edge, compare on the falling edge.
    task automatic step(int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            if (resetb) begin
                model_edge(0);
                model_edge(1);
            end
            @(negedge clk);
            compare_all();
        end
    endtask

    // Short resetb glitch between clock edges; called right after a falling edge.
    task automatic glitch();
        #2 resetb = 1'b0;
        model_reset();
        #1;
        check("glitch_sr0",    32'(sr0),    32'h7);
        check("glitch_done0",  32'(done0),  32'h0);
        check("glitch_cause0", 32'(cause0), 32'h0);
        check("glitch_sr1",    32'(sr1),    32'h1);
        #4 resetb = 1'b1;
    endtask

    initial begin
        resetb       = 1'b0;
        ext_btn      = 1'b0;
        sw_reset_req = 1'b0;
        model_reset();

        // Power-on: three cycles in reset, release before edge 1.
        step(3);
        check("por_sr0", 32'(sr0), 32'h7);
        check("por_done0", 32'(done0), 32'h0);
        resetb = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step(1);
            if (e == 17) check("por_e17", 32'(sr0), 32'h7);
            if (e == 18) check("por_e18", 32'(sr0), 32'h6);
            if (e == 25) check("por_e25", 32'(sr0), 32'h6);
            if (e == 26) check("por_e26", 32'(sr0), 32'h4);
            if (e == 33) check("por_e33", {31'd0, done0}, 32'h0);
            if (e == 34) check("por_e34", {28'd0, sr0, done0}, 32'h1);
            if (e == 3)  check("swp_e3",  {30'd0, sr1, done1}, 32'h2);
            if (e == 4)  check("swp_e4",  {30'd0, sr1, done1}, 32'h1);
        end
        check("por_cause", 32'(cause0), 32'h0);

        // Software reset pulse from RUN.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check("sw_sr",    32'(sr0),    32'h7);
        check("sw_done",  32'(done0),  32'h0);
        check("sw_cause", 32'(cause0), 32'h2);
        step(40);

        // Bouncy button: 3 high / 1 low never qualifies.
        for (int r = 0; r < 6; r++) begin
            ext_btn = 1'b1; step(3);
            ext_btn = 1'b0; step(1);
        end
        check("bounce_done", 32'(done0), 32'h1);
        ext_btn = 1'b1;
        step(20);
        check("btn_sr",    32'(sr0),    32'h7);
        check("btn_cause", 32'(cause0), 32'h1);
        ext_btn = 1'b0;
        step(45);

        // Mid-sequence restart while bit 0 is already released.
        sw_reset_req = 1'b1; step(1); sw_reset_req = 1'b0;
        step(16);
        check("mid_pre", 32'(sr0), 32'h6);
        sw_reset_req = 1'b1; step(1); sw_reset_req = 1'b0;
        check("mid_reassert", 32'(sr0), 32'h7);
        step(15);
        check("mid_hold", 32'(sr0), 32'h7);
        step(1);
        check("mid_bit0", 32'(sr0), 32'h6);
        step(30);

        // Simultaneous triggers: software pulse while the button is qualified.
        ext_btn = 1'b1;
        step(8);
        sw_reset_req = 1'b1; step(1); sw_reset_req = 1'b0;
        check("both_cause", 32'(cause0), 32'h1);
        ext_btn = 1'b0;
        step(3);
        glitch();
        step(40);

        // Randomised traffic with occasional resetb glitches.
        for (int c = 0; c < 600; c++) begin
            sw_reset_req = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) ext_btn = ~ext_btn;
            if ($urandom_range(0, 299) == 0) glitch();
            step(1);
        end
        sw_reset_req = 1'b0;
        ext_btn      = 1'b0;
        step(50);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
